// File: rtl/mdu_div.sv
// ---------------------------------------------------------------------------
// mdu_div -- multi-cycle divider for the MIPS multiply/divide unit.
//
// Executes DIV (signed, instr=1) and DIVU (unsigned, instr=0) by restoring
// shift-subtract, one quotient bit per clock. The quotient goes to lo and the
// remainder to hi. Signed operands are divided as magnitudes and the signs are
// re-applied at the end: the quotient truncates toward zero and the remainder
// takes the sign of the dividend.
//
// Timing (WIDTH=32): the start edge loads the operands, 32 RUN cycles follow,
// then one FIX cycle registers the result. busy is high for 33 cycles and done
// is high in the cycle that the 34th edge after the start edge samples.
//
// Optional feature, macro DIV_ZERO_DETECT_EN:
//   defined   - adds output div_zero. A zero divisor skips RUN and produces
//               lo=all ones, hi=a, with div_zero high alongside done.
//   undefined - a zero divisor runs the full algorithm, and lo/hi are whatever
//               the algorithm yields.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset; clears busy, done,
//                         lo, hi and aborts any operation in flight
//   a         in   WIDTH  dividend (rs)
//   b         in   WIDTH  divisor (rt)
//   instr     in   1      1 = DIV signed, 0 = DIVU unsigned
//   start     in   1      request, sampled only while idle
//   busy      out  1      high while an operation is in flight
//   done      out  1      one-cycle pulse: lo/hi hold the new result
//   lo        out  WIDTH  quotient, held until the next completion
//   hi        out  WIDTH  remainder, held until the next completion
//   div_zero  out  1      (DIV_ZERO_DETECT_EN only) zero divisor, with done
// ---------------------------------------------------------------------------
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             instr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
`ifdef DIV_ZERO_DETECT_EN
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] hi
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude of an operand. The most negative value maps onto itself, which
  // reads correctly as the unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (is_signed && (sv < 0)) return $unsigned(-sv);
    return v;
  endfunction

  // Conditional two's-complement negation used to re-apply result signs.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (neg) return $unsigned(-sv);
    return v;
  endfunction

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  // Datapath state (no reset: always loaded on the start edge before use)
  logic [WIDTH-1:0] quot_q, quot_d;     // dividend shifting out, quotient in
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

`ifdef DIV_ZERO_DETECT_EN
  logic             div_zero_q, div_zero_d;
  logic             dz_pend_q, dz_pend_d;
`endif

  // One restoring step. The subtraction is WIDTH+1 bits wide so a shifted
  // remainder above 2^WIDTH-1 still compares correctly; the top bit of the
  // difference is the borrow.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lo_d       = lo_q;
    hi_d       = hi_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`ifdef DIV_ZERO_DETECT_EN
    div_zero_d = 1'b0;
    dz_pend_d  = dz_pend_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          quot_d     = abs_val(a, instr);
          dvsr_d     = abs_val(b, instr);
          neg_quot_d = instr & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = instr & a[WIDTH-1];
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
`ifdef DIV_ZERO_DETECT_EN
          // A zero divisor goes straight to FIX with the dividend magnitude
          // as remainder, so the usual sign fix-up returns hi = a.
          dz_pend_d = (b == '0);
          if (b == '0) begin
            rem_d   = abs_val(a, instr);
            state_d = FIX;
          end
`endif
        end
      end

      RUN: begin
        if (!diff[WIDTH]) begin
          rem_d  = diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        lo_d    = cond_neg(quot_q, neg_quot_q);
        hi_d    = cond_neg(rem_q, neg_rem_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
        if (dz_pend_q) lo_d = '1;
        div_zero_d = dz_pend_q;
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    quot_q     <= quot_d;
    rem_q      <= rem_d;
    dvsr_q     <= dvsr_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
`ifdef DIV_ZERO_DETECT_EN
    dz_pend_q  <= dz_pend_d;
`endif
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_mdu_div.sv
// ---------------------------------------------------------------------------
// tb_mdu_div -- directed, table-driven bench for mdu_div (WIDTH=32).
// Latency is counted in falling edges after the start edge: done first seen
// at falling edge n means the rising edge n after the start edge samples it.
// ---------------------------------------------------------------------------
module tb_mdu_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic         instr;
  logic         start;
  logic         busy, done;
  logic [W-1:0] lo, hi;
`ifdef DIV_ZERO_DETECT_EN
  logic         div_zero;
`endif

  mdu_div #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .instr   (instr),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .lo      (lo),
`ifdef DIV_ZERO_DETECT_EN
    .hi      (hi),
    .div_zero(div_zero)
`else
    .hi      (hi)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] cur_lo, cur_hi;   // result lo/hi are expected to hold

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         instr;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present an operation at a falling edge, let the next rising edge take it,
  // then scramble the operands to show they are not needed after the start edge.
  task automatic drive(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ins);
    a = ai; b = bi; instr = ins; start = 1'b1;
  endtask

  task automatic launch();
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    instr = 1'($urandom);
  endtask

  // Wait for done after a launch. poke_at > 0 raises start (with 9/3) in that
  // cycle to show a request during busy is ignored. Returns at the falling
  // edge where done is high.
  task automatic wait_done(input string nm, input int exp_lat, input int exp_busy,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                           input logic exp_dz, input int poke_at);
    int lat;
    int busy_n;
    bit held;
    lat = 101; busy_n = 0; held = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_n++;
      if (lo !== cur_lo || hi !== cur_hi) held = 1'b0;
      if (n == poke_at) begin
        a = 32'd9; b = 32'd3; instr = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, W'(lat), W'(exp_lat));
    chk({nm, "_busy_cycles"}, W'(busy_n), W'(exp_busy));
    chk({nm, "_hold"}, W'(held), W'(1));
    chk({nm, "_lo"}, lo, exp_lo);
    chk({nm, "_hi"}, hi, exp_hi);
`ifdef DIV_ZERO_DETECT_EN
    chk({nm, "_div_zero"}, W'(div_zero), W'(exp_dz));
`else
    if (exp_dz) begin end
`endif
    cur_lo = exp_lo;
    cur_hi = exp_hi;
  endtask

  task automatic pulse_end(input string nm);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, W'(done), W'(0));
    chk({nm, "_busy_after"}, W'(busy), W'(0));
  endtask

  initial begin
    int lat, busy_n, dz_lat, dz_busy;
    logic dz;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0};
    vecs[7]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE};
    vecs[8]  = '{32'd3,        32'd10,       1'b0, 32'd0,        32'd3};
    vecs[9]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'd0,        32'hFFFFFFFE};
    vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd1,        32'h7FFFFFFF};
    vecs[11] = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5};
`ifdef DIV_ZERO_DETECT_EN
    vecs[12] = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB};
    dz_lat = 2; dz_busy = 1;
`else
    vecs[12] = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'd1,        32'hFFFFFFFB};
    dz_lat = 34; dz_busy = 33;
`endif

    reset = 1'b1; start = 1'b0; a = '0; b = '0; instr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_lo", lo, 32'd0);
    chk("reset_hi", hi, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    chk("reset_div_zero", W'(div_zero), W'(0));
`endif
    cur_lo = '0; cur_hi = '0;

    for (int i = 0; i < 13; i++) begin
      dz = (vecs[i].b == '0);
`ifdef DIV_ZERO_DETECT_EN
      lat = dz ? dz_lat : 34; busy_n = dz ? dz_busy : 33;
`else
      lat = 34; busy_n = 33;
      if (dz_lat != 34) lat = dz_lat;
`endif
      drive(vecs[i].a, vecs[i].b, vecs[i].instr);
      launch();
      wait_done($sformatf("vec%0d", i), lat, busy_n, vecs[i].exp_lo, vecs[i].exp_hi,
`ifdef DIV_ZERO_DETECT_EN
                dz,
`else
                1'b0,
`endif
                0);
      pulse_end($sformatf("vec%0d", i));
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0);
    launch();
    wait_done("busy_start", 34, 33, 32'd14, 32'd2, 1'b0, 5);
    drive(32'd9, 32'd3, 1'b0);
    launch();
    wait_done("done_cycle_start", 34, 33, 32'd3, 32'd0, 1'b0, 0);
    pulse_end("done_cycle_start");

    // Reset ten cycles into an operation aborts it and clears lo/hi.
    @(negedge clk);
    drive(32'd1000, 32'd3, 1'b0);
    launch();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    cur_lo = '0; cur_hi = '0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_no_done", W'(seen), W'(0));
    end

    // Recovers normally after the abort.
    drive(32'd1000, 32'd3, 1'b0);
    launch();
    wait_done("after_abort", 34, 33, 32'd333, 32'd1, 1'b0, 0);
    pulse_end("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hang regardless of DUT behaviour.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
